// File: rtl/rvdff_skid.sv
// Registered valid/ready slice with a two-entry skid buffer: every output,
// including the upstream ready, comes straight from a flop.
module rvdff_skid #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  input  logic             io_flush,
  output logic [1:0]       io_count
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] bits;
  } entry_t;

  entry_t main_q, skid_q;
  logic   in_fire, out_fire;

  // Skid only fills while main is occupied, so a free skid slot means room.
  assign io_in_ready  = ~skid_q.valid;
  assign io_out_valid = main_q.valid;
  assign io_out_bits  = main_q.bits;
  assign io_count     = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

  assign in_fire  = io_in_valid & io_in_ready;
  assign out_fire = io_out_valid & io_out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (io_flush) begin
      // Payload registers are left as-is; only occupancy is discarded.
      main_q.valid <= 1'b0;
      skid_q.valid <= 1'b0;
    end else if (skid_q.valid) begin
      if (out_fire) begin
        main_q.bits  <= skid_q.bits;
        skid_q.valid <= 1'b0;
      end
    end else if (main_q.valid) begin
      if (out_fire) begin
        main_q.valid <= in_fire;
        if (in_fire) main_q.bits <= io_in_bits;
      end else if (in_fire) begin
        skid_q.valid <= 1'b1;
        skid_q.bits  <= io_in_bits;
      end
    end else if (in_fire) begin
      main_q.valid <= 1'b1;
      main_q.bits  <= io_in_bits;
    end
  end

endmodule

// File: tb/tb_rvdff_skid.sv
// Bench for rvdff_skid: directed scenarios plus a randomized run against a
// two-deep FIFO queue model.
module tb_rvdff_skid;
  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             io_in_valid = 1'b0;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits = '0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b0;
  logic [WIDTH-1:0] io_out_bits;
  logic             io_flush = 1'b0;
  logic [1:0]       io_count;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] mq[$];

  rvdff_skid #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
    .io_flush(io_flush), .io_count(io_count)
  );

  always #5 clock = ~clock;

  // Advance one clock and update the FIFO model from the inputs driven this cycle.
  task automatic tick();
    bit inf, outf;
    inf  = io_in_valid && (mq.size() < 2);
    outf = (mq.size() > 0) && io_out_ready;
    @(posedge clock); #1;
    if (io_flush) mq.delete();
    else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(io_in_bits);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({io_out_valid, io_in_ready, io_count} !== 4'b0100 || io_out_bits !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b count=%0d bits=%h, want 0 1 0 0000",
               io_out_valid, io_in_ready, io_count, io_out_bits);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_first();
    io_in_valid = 1'b1; io_in_bits = 16'h1234; io_out_ready = 1'b1;
    tick();
    io_in_valid = 1'b0;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_bits !== 16'h1234 || io_in_ready !== 1'b1 || io_count !== 2'd1) begin
      errors++;
      $display("FAIL first: valid=%b bits=%h ready=%b count=%0d, want 1 1234 1 1",
               io_out_valid, io_out_bits, io_in_ready, io_count);
    end
    tick();
    checks++;
    if (io_out_valid !== 1'b0 || io_count !== 2'd0) begin
      errors++;
      $display("FAIL first_drain: valid=%b count=%0d, want 0 0", io_out_valid, io_count);
    end
  endtask

  task automatic test_back_to_back();
    io_out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      io_in_valid = (i <= 16);
      io_in_bits  = WIDTH'(i);
      if (i > 1) begin
        checks++;
        if (io_out_valid !== 1'b1 || io_out_bits !== WIDTH'(i - 1) || io_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream[%0d]: valid=%b bits=%h ready=%b, want 1 %h 1",
                   i - 1, io_out_valid, io_out_bits, io_in_ready, WIDTH'(i - 1));
        end
      end
      tick();
    end
    io_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    io_out_ready = 1'b0;
    io_in_valid = 1'b1; io_in_bits = 16'hAAAA; tick();
    io_in_bits = 16'hBBBB; tick();
    io_in_valid = 1'b0;
    checks++;
    if (io_count !== 2'd2 || io_in_ready !== 1'b0 || io_out_bits !== 16'hAAAA || io_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_full: count=%0d ready=%b bits=%h valid=%b, want 2 0 aaaa 1",
               io_count, io_in_ready, io_out_bits, io_out_valid);
    end
    tick();
    checks++;
    if (io_count !== 2'd2 || io_out_bits !== 16'hAAAA) begin
      errors++;
      $display("FAIL stall_hold: count=%0d bits=%h, want 2 aaaa", io_count, io_out_bits);
    end
    io_out_ready = 1'b1;
    tick();
    checks++;
    if (io_out_bits !== 16'hBBBB || io_out_valid !== 1'b1 || io_in_ready !== 1'b1 || io_count !== 2'd1) begin
      errors++;
      $display("FAIL stall_drain1: bits=%h valid=%b ready=%b count=%0d, want bbbb 1 1 1",
               io_out_bits, io_out_valid, io_in_ready, io_count);
    end
    tick();
    checks++;
    if (io_out_valid !== 1'b0 || io_count !== 2'd0) begin
      errors++;
      $display("FAIL stall_drain2: valid=%b count=%0d, want 0 0", io_out_valid, io_count);
    end
  endtask

  task automatic test_flush();
    io_out_ready = 1'b0;
    io_in_valid = 1'b1; io_in_bits = 16'h1111; tick();
    io_in_bits = 16'h2222; tick();
    io_flush = 1'b1; io_in_bits = 16'hCCCC; tick();
    io_flush = 1'b0; io_in_valid = 1'b0;
    checks++;
    if (io_count !== 2'd0 || io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: count=%0d valid=%b ready=%b, want 0 0 1", io_count, io_out_valid, io_in_ready);
    end
    io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (io_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak[%0d]: valid=%b bits=%h, want valid 0", i, io_out_valid, io_out_bits);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    io_out_ready = 1'b0;
    io_in_valid = 1'b1; io_in_bits = 16'h7777; tick();
    io_in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    mq.delete();
    checks++;
    if (io_out_valid !== 1'b0 || io_out_bits !== '0 || io_count !== 2'd0 || io_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b bits=%h count=%0d ready=%b, want 0 0000 0 1",
               io_out_valid, io_out_bits, io_count, io_in_ready);
    end
    @(posedge clock); #3 reset = 1'b0;
    @(posedge clock); #1;
    io_in_valid = 1'b1; io_in_bits = 16'h5555; io_out_ready = 1'b1; tick();
    io_in_valid = 1'b0;
    checks++;
    if (io_out_valid !== 1'b1 || io_out_bits !== 16'h5555 || io_count !== 2'd1) begin
      errors++;
      $display("FAIL post_reset: valid=%b bits=%h count=%0d, want 1 5555 1",
               io_out_valid, io_out_bits, io_count);
    end
    tick();
  endtask

  task automatic test_random();
    bit               was_stalled = 1'b0;
    logic [WIDTH-1:0] held = '0;
    int               bad = 0;
    for (int c = 0; c < 10000; c++) begin
      io_in_valid  = 1'($urandom_range(0, 1));
      io_out_ready = 1'($urandom_range(0, 1));
      io_in_bits   = WIDTH'($urandom);
      io_flush     = ($urandom_range(0, 63) == 0);
      checks++;
      if (io_out_valid !== (mq.size() > 0) || io_in_ready !== (mq.size() < 2) ||
          io_count !== 2'(mq.size()) || (mq.size() > 0 && io_out_bits !== mq[0]) ||
          (was_stalled && (io_out_valid !== 1'b1 || io_out_bits !== held))) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: valid=%b ready=%b count=%0d bits=%h, model depth=%0d head=%h",
                   c, io_out_valid, io_in_ready, io_count, io_out_bits, mq.size(),
                   (mq.size() > 0) ? mq[0] : '0);
      end
      was_stalled = io_out_valid && !io_out_ready && !io_flush;
      held        = io_out_bits;
      tick();
    end
    io_in_valid = 1'b0; io_flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
